i2c_target_regs: RTL and testbench

I2C target (slave) responder with an 8-entry × 8-bit register file, forming the far end of the bus driven by the APB-to-I2C bridge. It oversamples `i2c_scl`/`i2c_sda` on `PCLK` and decodes START/STOP conditions. It matches a 7-bit device address, accepts a register pointer, and then serves auto-incrementing register writes and reads. Local logic observes every write through a strobe and can read any register combinationally.

---
 rtl/i2c_target_regs.sv | 208 ++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target responder with an 8 x 8-bit register file.
// SCL/SDA are oversampled on PCLK. After an address match the first written
// byte sets the register pointer; further written bytes land in the register
// file with auto-increment, and reads stream out from the pointer with
// auto-increment. Local logic sees each write as a one-cycle strobe and can
// read any register combinationally.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | bus free or after STOP, waiting for START
// ST_ADDR      | shifting in the address byte (7-bit address + R/W)
// ST_ADDR_ACK  | driving ACK for a matched address, then branch on R/W
// ST_PTR       | shifting in the register pointer byte
// ST_PTR_ACK   | driving ACK for the pointer byte
// ST_WDATA     | shifting in a write data byte
// ST_WDATA_ACK | driving ACK for a write data byte
// ST_RDATA     | shifting a register out on SDA, MSB first
// ST_RACK      | SDA released, sampling the controller's ACK/NACK
// ST_IGNORE    | not addressed or NACKed, SDA released until START/STOP
module i2c_target_regs #(
  parameter logic [6:0] I2C_ADDR = 7'h50
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic       busy,
  output logic       wr_strobe,
  output logic [2:0] wr_index,
  output logic [7:0] wr_data,
  input  logic [2:0] loc_idx,
  output logic [7:0] loc_rdata
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } state_t;

  state_t     state;
  logic       scl_s1, scl_s2, scl_d;
  logic       sda_s1, sda_s2, sda_d;
  logic [7:0] sr;
  logic [3:0] bit_cnt;
  logic [2:0] ptr;
  logic [2:0] ptr_nxt;
  logic       sda_oe;
  logic       ack_on;
  logic [7:0] regs [8];

  logic       scl_rise, scl_fall, start_cond, stop_cond, byte_done;
  logic [7:0] rx_byte;

  // Open-drain pad: only ever pull low or let go. sda_oe is cleared by the
  // async reset, so the bus is released the instant PRESETn asserts.
  assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

  assign loc_rdata = regs[loc_idx];

  // Bus events are decoded from the synchronized samples and their history.
  assign scl_rise   =  scl_s2 & ~scl_d;
  assign scl_fall   = ~scl_s2 &  scl_d;
  assign start_cond =  scl_s2 &  scl_d & sda_d & ~sda_s2;
  assign stop_cond  =  scl_s2 &  scl_d & ~sda_d & sda_s2;
  assign rx_byte    = {sr[6:0], sda_s2};
  assign byte_done  = scl_rise && (bit_cnt == 4'd7);
  assign ptr_nxt    = ptr + 3'd1;

  // Two-flop synchronizers plus one history flop per bus line.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= i2c_scl;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= i2c_sda;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  // Protocol FSM, register file and write strobe. START outranks STOP when
  // both decode in the same cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= ST_IDLE;
      sr        <= 8'h00;
      bit_cnt   <= 4'd0;
      ptr       <= 3'd0;
      sda_oe    <= 1'b0;
      ack_on    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_index  <= 3'd0;
      wr_data   <= 8'h00;
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      if (start_cond) begin
        state   <= ST_ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        ack_on  <= 1'b0;
      end else if (stop_cond) begin
        state   <= ST_IDLE;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        ack_on  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise) begin
              sr <= rx_byte;
              if (byte_done) begin
                bit_cnt <= 4'd0;
                if (state == ST_ADDR) begin
                  if (rx_byte[7:1] == I2C_ADDR) begin
                    state <= ST_ADDR_ACK;
                    busy  <= 1'b1;
                  end else begin
                    state <= ST_IGNORE;
                    busy  <= 1'b0;
                  end
                end else if (state == ST_PTR) begin
                  ptr   <= rx_byte[2:0];
                  state <= ST_PTR_ACK;
                end else begin
                  regs[ptr] <= rx_byte;
                  wr_strobe <= 1'b1;
                  wr_index  <= ptr;
                  wr_data   <= rx_byte;
                  ptr       <= ptr_nxt;
                  state     <= ST_WDATA_ACK;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            // First fall starts the ACK, second fall (after the 9th clock) ends it.
            if (scl_fall) begin
              if (!ack_on) begin
                ack_on <= 1'b1;
                sda_oe <= 1'b1;
              end else begin
                ack_on  <= 1'b0;
                bit_cnt <= 4'd0;
                if (state == ST_ADDR_ACK && sr[0]) begin
                  // Read: the first data bit goes out on this same fall.
                  state  <= ST_RDATA;
                  sda_oe <= ~regs[ptr][7];
                  sr     <= {regs[ptr][6:0], 1'b0};
                end else begin
                  sda_oe <= 1'b0;
                  state  <= (state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                end
              end
            end
          end
          ST_RDATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= ST_RACK;
              end else begin
                sda_oe <= ~sr[7];
                sr     <= {sr[6:0], 1'b0};
              end
            end else if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          ST_RACK: begin
            if (scl_rise) begin
              ptr <= ptr_nxt;
              if (!sda_s2) begin
                sr      <= regs[ptr_nxt];
                bit_cnt <= 4'd0;
                state   <= ST_RDATA;
              end else begin
                state <= ST_IGNORE;
                busy  <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C controller, register/pointer
// reference model, and a monitor collecting write strobes.
module tb_i2c_target_regs;

  localparam int Q = 100;

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       scl = 1'b1;
  logic       ctrl_low = 1'b0;
  wire        sda_bus;
  logic       busy, wr_strobe;
  logic [2:0] wr_index;
  logic [7:0] wr_data;
  logic [2:0] loc_idx = 3'd0;
  logic [7:0] loc_rdata;

  assign sda_bus = ctrl_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_target_regs #(.I2C_ADDR(7'h50)) dut (
    .PCLK      (pclk),
    .PRESETn   (presetn),
    .i2c_scl   (scl),
    .i2c_sda   (sda_bus),
    .busy      (busy),
    .wr_strobe (wr_strobe),
    .wr_index  (wr_index),
    .wr_data   (wr_data),
    .loc_idx   (loc_idx),
    .loc_rdata (loc_rdata)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model
  logic [7:0] m_regs [8];
  int         m_ptr;
  int         wbuf[$];
  int         exp_idx[$], exp_dat[$], obs_idx[$], obs_dat[$];
  logic       tgt_drove = 1'b0;

  always @(negedge pclk) begin
    if (wr_strobe) begin
      obs_idx.push_back(int'(wr_index));
      obs_dat.push_back(int'(wr_data));
    end
    if (!ctrl_low && sda_bus === 1'b0) tgt_drove = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic bus_start();
    ctrl_low = 1'b0; #Q; scl = 1'b1; #Q; ctrl_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    ctrl_low = 1'b1; #Q; scl = 1'b1; #Q; ctrl_low = 1'b0; #Q;
  endtask

  task automatic send_bit(input logic b);
    ctrl_low = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic recv_bit(output logic b);
    ctrl_low = 1'b0; #Q; scl = 1'b1; #Q; b = sda_bus; #Q; scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack_lvl);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack_lvl);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  // Write transaction: pointer byte p, then the bytes queued in wbuf.
  task automatic do_write(input int p);
    logic ack;
    bus_start();
    send_byte(8'hA0, ack);
    check("wr_addr_ack", ack, 0);
    check("wr_busy", busy, 1);
    send_byte(8'(p), ack);
    check("wr_ptr_ack", ack, 0);
    m_ptr = p & 7;
    foreach (wbuf[k]) begin
      send_byte(8'(wbuf[k]), ack);
      check("wr_data_ack", ack, 0);
      m_regs[m_ptr] = 8'(wbuf[k]);
      exp_idx.push_back(m_ptr);
      exp_dat.push_back(wbuf[k] & 255);
      m_ptr = (m_ptr + 1) % 8;
    end
    bus_stop();
    check("wr_busy_after_stop", busy, 0);
  endtask

  // Read n bytes, optionally setting the pointer first via repeated START.
  task automatic do_read(input logic with_ptr, input int p, input int n);
    logic ack;
    logic [7:0] d;
    bus_start();
    if (with_ptr) begin
      send_byte(8'hA0, ack);
      check("rd_waddr_ack", ack, 0);
      send_byte(8'(p), ack);
      check("rd_ptr_ack", ack, 0);
      m_ptr = p & 7;
      bus_start();
    end
    send_byte(8'hA1, ack);
    check("rd_addr_ack", ack, 0);
    for (int k = 0; k < n; k++) begin
      recv_byte(d, (k == n - 1));
      check("rd_data", d, m_regs[m_ptr]);
      m_ptr = (m_ptr + 1) % 8;
    end
    check("rd_sda_released", sda_bus, 1);
    check("rd_busy_after_nack", busy, 0);
    bus_stop();
  endtask

  task automatic check_strobes(input string tag);
    check({tag, "_count"}, obs_idx.size(), exp_idx.size());
    for (int k = 0; k < obs_idx.size() && k < exp_idx.size(); k++) begin
      check({tag, "_idx"}, obs_idx[k], exp_idx[k]);
      check({tag, "_dat"}, obs_dat[k], exp_dat[k]);
    end
    obs_idx.delete(); obs_dat.delete(); exp_idx.delete(); exp_dat.delete();
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      loc_idx = 3'(i);
      #1;
      check(tag, loc_rdata, m_regs[i]);
    end
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         p, n, a;

    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_ptr = 0;

    // reset state
    #53;
    check("rst_busy", busy, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_wr_index", wr_index, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_sda", sda_bus, 1);
    check_regs("rst_reg");
    presetn = 1'b1;
    #(2*Q);

    // pointer write
    wbuf = '{8'h11, 8'h22};
    do_write(8'h03);
    check_strobes("ptr_wr_strobe");
    loc_idx = 3'd4; #1;
    check("ptr_wr_loc4", loc_rdata, 8'h22);

    // repeated-START read: 0x11 then 0x22
    do_read(1'b1, 8'h03, 2);
    check_strobes("rs_rd_strobe");

    // pointer wrap
    wbuf = '{8'hAA, 8'hBB};
    do_write(8'h07);
    check_strobes("wrap_strobe");
    loc_idx = 3'd7; #1;
    check("wrap_reg7", loc_rdata, 8'hAA);
    loc_idx = 3'd0; #1;
    check("wrap_reg0", loc_rdata, 8'hBB);

    // randomized writes and reads against the model
    for (int it = 0; it < 5; it++) begin
      p = int'($urandom_range(0, 255));
      n = int'($urandom_range(1, 5));
      wbuf.delete();
      for (int k = 0; k < n; k++) wbuf.push_back(int'($urandom_range(0, 255)));
      do_write(p);
      check_strobes("rnd_wr_strobe");
      do_read(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(1, 4)));
      check_strobes("rnd_rd_strobe");
    end
    check_regs("rnd_reg");

    // address mismatch: fixed 0x51 then a random non-matching address
    for (int t = 0; t < 2; t++) begin
      a = (t == 0) ? 32'h51 : int'($urandom_range(0, 127));
      if (a == 32'h50) a = 32'h2A;
      tgt_drove = 1'b0;
      bus_start();
      send_byte(8'(a << 1), ack);
      check("mm_nack", ack, 1);
      check("mm_busy", busy, 0);
      send_byte(8'h33, ack);
      check("mm_data_nack", ack, 1);
      bus_stop();
      check("mm_sda_never_driven", tgt_drove, 0);
      check_strobes("mm_strobe");
    end
    check_regs("mm_reg");

    // abort by START after 4 bits of 0xFF aimed at reg5
    bus_start();
    send_byte(8'hA0, ack);
    check("abort_addr_ack", ack, 0);
    send_byte(8'h05, ack);
    check("abort_ptr_ack", ack, 0);
    m_ptr = 5;
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus_start();
    send_byte(8'hA0, ack);
    check("abort_readdr_ack", ack, 0);
    bus_stop();
    check_strobes("abort_strobe");
    loc_idx = 3'd5; #1;
    check("abort_reg5", loc_rdata, m_regs[5]);

    // reset mid-transfer during a read-data 0 bit
    wbuf = '{8'h3C};
    do_write(8'h02);
    check_strobes("mr_setup_strobe");
    bus_start();
    send_byte(8'hA0, ack);
    send_byte(8'h02, ack);
    m_ptr = 2;
    bus_start();
    send_byte(8'hA1, ack);
    check("mr_addr_ack", ack, 0);
    check("mr_target_drives_0", sda_bus, 0);
    check("mr_busy_pre", busy, 1);
    presetn = 1'b0;
    #1;
    check("mr_sda_released", sda_bus, 1);
    check("mr_busy", busy, 0);
    check("mr_wr_strobe", wr_strobe, 0);
    check("mr_wr_index", wr_index, 0);
    check("mr_wr_data", wr_data, 0);
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    check_regs("mr_reg");
    #50;
    presetn = 1'b1;
    #Q;
    bus_stop();
    obs_idx.delete(); obs_dat.delete();
    do_read(1'b0, 0, 1);
    check_strobes("mr_post_strobe");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
